fx_invcdf_rational_seq: RTL and testbench

- Sequential, parametrised successor to the fixed Zelen–Severo inverse-CDF stage.
- Evaluates z = ±(t − N(t)/D(t)) with runtime-selectable coefficient sets, Horner evaluation and an internal bit-serial divider.
- Carries a sideband tag and flags bad inputs.
- Sits between the sqrt(−2·ln p) stage and the path generator in the QMC normal-variate pipeline.

---
 rtl/fx_invcdf_rational_seq.sv | 199 +++++++++++++++++++
 tb/tb_fx_invcdf_rational_seq.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx_invcdf_rational_seq.sv
// Sequential rational inverse-CDF stage: z = +/-(t - N(t)/D(t)) with Horner evaluation
// of N and D followed by a bit-serial restoring divider; tag and clamp flag ride along.
module fx_invcdf_rational_seq #(
  parameter int     WIDTH = 32,
  parameter int     QFRAC = 16,
  parameter int     TAG_W = 4,
  parameter longint T_MAX = longint'(16) << QFRAC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic signed [WIDTH-1:0] t,
  input  logic                    negate,
  input  logic                    mode,
  input  logic [TAG_W-1:0]        tag_in,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic signed [WIDTH-1:0] z,
  output logic [TAG_W-1:0]        tag_out,
  output logic                    err
);

  localparam int     CNT_W   = $clog2(WIDTH);
  localparam longint L_SCALE = longint'(1) << QFRAC;

  function automatic logic signed [WIDTH-1:0] coef(input longint k);
    return WIDTH'((k * L_SCALE) / 1000000);
  endfunction

  localparam logic signed [WIDTH-1:0] L_ONE   = WIDTH'(L_SCALE);
  localparam logic signed [WIDTH-1:0] L_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] L_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] L_TMAX  = WIDTH'(T_MAX);
  localparam logic signed [2*WIDTH-1:0] L_MAX_W = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] L_MIN_W = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  // Zelen-Severo set (mode 0)
  localparam logic signed [WIDTH-1:0] M0_C0 = coef(2515517);
  localparam logic signed [WIDTH-1:0] M0_C1 = coef(802853);
  localparam logic signed [WIDTH-1:0] M0_C2 = coef(10328);
  localparam logic signed [WIDTH-1:0] M0_D1 = coef(1432788);
  localparam logic signed [WIDTH-1:0] M0_D2 = coef(189269);
  localparam logic signed [WIDTH-1:0] M0_D3 = coef(1308);
  // Abramowitz-Stegun 26.2.22 set (mode 1)
  localparam logic signed [WIDTH-1:0] M1_C0 = coef(2307530);
  localparam logic signed [WIDTH-1:0] M1_C1 = coef(270610);
  localparam logic signed [WIDTH-1:0] M1_D1 = coef(992290);
  localparam logic signed [WIDTH-1:0] M1_D2 = coef(44810);

  typedef enum logic [2:0] {S_IDLE, S_POLY, S_DIV, S_FIN, S_DONE} state_t;

  function automatic logic signed [2*WIDTH-1:0] ext(input logic signed [WIDTH-1:0] x);
    return {{WIDTH{x[WIDTH-1]}}, x};
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [2*WIDTH-1:0] x);
    if (x > L_MAX_W)      return L_MAX;
    else if (x < L_MIN_W) return L_MIN;
    else                  return x[WIDTH-1:0];
  endfunction

  state_t                    r_state, w_state_next;
  logic signed [WIDTH-1:0]   r_t, r_acc_n, r_acc_d, r_z;
  logic                      r_neg, r_mode, r_err_in, r_err, r_valid_out, r_ovf;
  logic [TAG_W-1:0]          r_tag, r_tag_out;
  logic [1:0]                r_step;
  logic [WIDTH-1:0]          r_rem, r_dvd, r_q;
  logic [CNT_W-1:0]          r_cnt;

  logic                      w_accept, w_clamp;
  logic signed [WIDTH-1:0]   w_t_cl, w_dcoef, w_ncoef, w_sum_d, w_sum_n;
  logic signed [2*WIDTH-1:0] w_mul_d, w_mul_n;
  logic [WIDTH:0]            w_trial;
  logic                      w_ge;
  logic [WIDTH-1:0]          w_rem_next;
  logic signed [WIDTH-1:0]   w_q_sat, w_r, w_z;

  assign ready_out = (r_state == S_IDLE) || (r_state == S_DONE && ready_in);
  assign w_accept  = valid_in && ready_out;
  assign valid_out = r_valid_out;
  assign z         = r_z;
  assign tag_out   = r_tag_out;
  assign err       = r_err;

  always_comb begin
    w_t_cl  = t;
    w_clamp = 1'b0;
    if (t[WIDTH-1]) begin
      w_t_cl  = '0;
      w_clamp = 1'b1;
    end else if (t > L_TMAX) begin
      w_t_cl  = L_TMAX;
      w_clamp = 1'b1;
    end
  end

  // r_step counts remaining Horner steps; D takes coefficient of power r_step-1,
  // N of power r_step-2, so N stops updating on the final step in both modes.
  always_comb begin
    w_dcoef = L_ONE;
    w_ncoef = r_mode ? M1_C0 : M0_C0;
    if (r_step == 2'd3) begin
      w_dcoef = M0_D2;
      w_ncoef = M0_C1;
    end else if (r_step == 2'd2) begin
      w_dcoef = r_mode ? M1_D1 : M0_D1;
    end
  end

  always_comb begin
    w_mul_d = ext(r_acc_d) * ext(r_t);
    w_mul_n = ext(r_acc_n) * ext(r_t);
    w_sum_d = sat_w(ext(sat_w(w_mul_d >>> QFRAC)) + ext(w_dcoef));
    w_sum_n = sat_w(ext(sat_w(w_mul_n >>> QFRAC)) + ext(w_ncoef));
  end

  always_comb begin
    w_trial    = {r_rem, r_dvd[WIDTH-1]};
    w_ge       = w_trial >= {1'b0, $unsigned(r_acc_d)};
    w_rem_next = w_ge ? WIDTH'(w_trial - {1'b0, $unsigned(r_acc_d)}) : w_trial[WIDTH-1:0];
  end

  always_comb begin
    w_q_sat = (r_ovf || r_q[WIDTH-1]) ? L_MAX : $signed(r_q);
    w_r     = sat_w(ext(r_t) - ext(w_q_sat));
    w_z     = r_neg ? sat_w(-ext(w_r)) : w_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = S_POLY;
      S_POLY: if (r_step == 2'd1) w_state_next = S_DIV;
      S_DIV:  if (r_cnt == CNT_W'(WIDTH-1)) w_state_next = S_FIN;
      S_FIN:  w_state_next = S_DONE;
      S_DONE: if (ready_in) w_state_next = w_accept ? S_POLY : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t <= '0; r_acc_n <= '0; r_acc_d <= '0; r_z <= '0;
      r_neg <= 1'b0; r_mode <= 1'b0; r_err_in <= 1'b0; r_err <= 1'b0;
      r_valid_out <= 1'b0; r_ovf <= 1'b0;
      r_tag <= '0; r_tag_out <= '0; r_step <= '0;
      r_rem <= '0; r_dvd <= '0; r_q <= '0; r_cnt <= '0;
    end else begin
      if (r_state == S_FIN)                    r_valid_out <= 1'b1;
      else if (r_state == S_DONE && ready_in)  r_valid_out <= 1'b0;

      if (w_accept) begin
        r_t      <= w_t_cl;
        r_err_in <= w_clamp;
        r_neg    <= negate;
        r_mode   <= mode;
        r_tag    <= tag_in;
        r_acc_n  <= mode ? M1_C1 : M0_C2;
        r_acc_d  <= mode ? M1_D2 : M0_D3;
        r_step   <= mode ? 2'd2 : 2'd3;
        r_ovf    <= 1'b0;
      end else begin
        case (r_state)
          S_POLY: begin
            r_acc_d <= w_sum_d;
            if (r_step >= 2'd2) r_acc_n <= w_sum_n;
            r_step <= r_step - 2'd1;
            // acc_n is final by the last step: preload dividend acc_n<<QFRAC
            r_rem <= $unsigned(r_acc_n) >> (WIDTH - QFRAC);
            r_dvd <= $unsigned(r_acc_n) << QFRAC;
            r_q   <= '0;
            r_cnt <= '0;
          end
          S_DIV: begin
            // a top remainder already >= divisor means the quotient needs > WIDTH bits
            if (r_cnt == '0 && r_rem >= $unsigned(r_acc_d)) r_ovf <= 1'b1;
            r_rem <= w_rem_next;
            r_dvd <= r_dvd << 1;
            r_q   <= {r_q[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
          end
          S_FIN: begin
            r_z       <= w_z;
            r_tag_out <= r_tag;
            r_err     <= r_err_in;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fx_invcdf_rational_seq.sv
// Bench for fx_invcdf_rational_seq: directed and random items checked against a
// plain-arithmetic rational-approximation model.
module tb_fx_invcdf_rational_seq;

  localparam int     QF   = 16;
  localparam longint TMAX = longint'(16) << QF;
  localparam longint MAXV = 64'h7FFF_FFFF;

  localparam longint K_C0 = (longint'(2515517) * 65536) / 1000000;
  localparam longint K_C1 = (longint'(802853)  * 65536) / 1000000;
  localparam longint K_C2 = (longint'(10328)   * 65536) / 1000000;
  localparam longint K_D1 = (longint'(1432788) * 65536) / 1000000;
  localparam longint K_D2 = (longint'(189269)  * 65536) / 1000000;
  localparam longint K_D3 = (longint'(1308)    * 65536) / 1000000;
  localparam longint A_C0 = (longint'(2307530) * 65536) / 1000000;
  localparam longint A_C1 = (longint'(270610)  * 65536) / 1000000;
  localparam longint A_D1 = (longint'(992290)  * 65536) / 1000000;
  localparam longint A_D2 = (longint'(44810)   * 65536) / 1000000;
  localparam longint ONE  = longint'(1) << QF;

  logic clk = 1'b0;
  logic rst_n, valid_in, ready_out, negate, mode, valid_out, ready_in, err;
  logic signed [31:0] t, z;
  logic [3:0] tag_in, tag_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fx_invcdf_rational_seq dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
    .t(t), .negate(negate), .mode(mode), .tag_in(tag_in),
    .valid_out(valid_out), .ready_in(ready_in), .z(z), .tag_out(tag_out), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Evaluate each polynomial from its highest power down, truncating each product.
  function automatic longint model_z(input longint tr, input bit neg, input bit md);
    longint tc, n, d, q, r;
    longint cn[$];
    longint cd[$];
    tc = (tr < 0) ? 0 : (tr > TMAX) ? TMAX : tr;
    if (!md) begin
      cn = '{K_C2, K_C1, K_C0};
      cd = '{K_D3, K_D2, K_D1, ONE};
    end else begin
      cn = '{A_C1, A_C0};
      cd = '{A_D2, A_D1, ONE};
    end
    n = 0;
    foreach (cn[i]) n = ((n * tc) >>> QF) + cn[i];
    d = 0;
    foreach (cd[i]) d = ((d * tc) >>> QF) + cd[i];
    q = (n <<< QF) / d;
    if (q > MAXV) q = MAXV;
    r = tc - q;
    return neg ? -r : r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [31:0] tv, input bit nv, input bit mv,
                      input logic [3:0] tg, output bit ok);
    t = tv; negate = nv; mode = mv; tag_in = tg; valid_in = 1'b1; ok = 1'b0;
    #1;
    for (int i = 0; i < 100; i++) begin
      if (ready_out) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    valid_in = 1'b0;
  endtask

  task automatic wait_result(output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      lat++;
      if (valid_out) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b1; t = '0; negate = 0; mode = 0; tag_in = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (valid_out !== 1'b0 || z !== 32'sd0 || tag_out !== 4'd0 || err !== 1'b0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid_out=%b z=%0d tag=%0d err=%b ready_out=%b, required 0 0 0 0 1",
               valid_out, z, tag_out, err, ready_out);
    end
    $display("reset released: valid_out=%b ready_out=%b", valid_out, ready_out);
  endtask

  task automatic run_item(input string name, input logic signed [31:0] tv, input bit nv,
                          input bit mv, input logic [3:0] tg, output longint got);
    bit ok;
    int lat, want_lat;
    longint exp_z;
    bit exp_err;
    exp_z   = model_z(longint'(tv), nv, mv);
    exp_err = (tv < 0) || (longint'(tv) > TMAX);
    want_lat = mv ? 35 : 36;
    ready_in = 1'b1;
    send(tv, nv, mv, tg, ok);
    wait_result(lat, ok);
    got = longint'(z);
    $display("%s: t=%0d neg=%0d mode=%0d -> z=%0d tag=%0d err=%0d lat=%0d", name, tv, nv, mv, z, tag_out, err, lat);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: no valid_out within 200 cycles", name);
    end else begin
      checks++;
      if (longint'(z) !== exp_z || err !== exp_err || tag_out !== tg) begin
        errors++;
        $display("FAIL %s_value: z=%0d err=%b tag=%0d, required z=%0d err=%b tag=%0d",
                 name, z, err, tag_out, exp_z, exp_err, tg);
      end
      checks++;
      if (lat !== want_lat) begin
        errors++;
        $display("FAIL %s_latency: %0d cycles, required %0d", name, lat, want_lat);
      end
    end
    tick();
  endtask

  task automatic test_zero();
    longint g;
    run_item("zero_pos", 32'sd0, 1'b0, 1'b0, 4'd1, g);
    checks++;
    if (g !== -64'sd164856) begin
      errors++;
      $display("FAIL zero_pos_const: z=%0d, required -164856", g);
    end
    run_item("zero_neg", 32'sd0, 1'b1, 1'b0, 4'd2, g);
    checks++;
    if (g !== 64'sd164856) begin
      errors++;
      $display("FAIL zero_neg_const: z=%0d, required 164856", g);
    end
  endtask

  task automatic test_two();
    longint g;
    run_item("two_m0", 32'sd131072, 1'b0, 1'b0, 4'd3, g);
    checks++;
    if (g < 72188 || g > 72196) begin
      errors++;
      $display("FAIL two_m0_approx: z=%0d, required 72192 +/-4", g);
    end
    run_item("two_m1", 32'sd131072, 1'b0, 1'b1, 4'd4, g);
    checks++;
    if (g < 72058 || g > 72066) begin
      errors++;
      $display("FAIL two_m1_approx: z=%0d, required 72062 +/-4", g);
    end
  endtask

  task automatic test_clamp();
    longint g_max, g_over, g_neg;
    run_item("neg_one", -32'sd1, 1'b0, 1'b0, 4'd5, g_neg);
    checks++;
    if (g_neg !== -64'sd164856 || err !== 1'b1) begin
      errors++;
      $display("FAIL neg_clamp: z=%0d err=%b, required -164856 1", g_neg, err);
    end
    run_item("t_max", 32'(TMAX), 1'b0, 1'b0, 4'd6, g_max);
    run_item("t_over", 32'(TMAX + 1), 1'b0, 1'b0, 4'd7, g_over);
    checks++;
    if (g_over !== g_max || err !== 1'b1) begin
      errors++;
      $display("FAIL over_clamp: z=%0d err=%b, required z=%0d err=1", g_over, err, g_max);
    end
  endtask

  task automatic test_backpressure();
    bit ok, stable;
    int lat;
    logic signed [31:0] z0, t1, t2;
    logic [3:0] tg0;
    t1 = 32'($urandom_range(0, 32'(TMAX)));
    t2 = 32'($urandom_range(0, 32'(TMAX)));
    ready_in = 1'b0;
    send(t1, 1'b0, 1'b0, 4'd10, ok);
    wait_result(lat, ok);
    z0 = z; tg0 = tag_out;
    $display("hold: t=%0d -> z=%0d tag=%0d lat=%0d", t1, z, tag_out, lat);
    checks++;
    if (!ok || longint'(z0) !== model_z(longint'(t1), 1'b0, 1'b0) || tg0 !== 4'd10) begin
      errors++;
      $display("FAIL hold_first: ok=%b z=%0d tag=%0d, required z=%0d tag=10",
               ok, z0, tg0, model_z(longint'(t1), 1'b0, 1'b0));
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid_out !== 1'b1 || z !== z0 || tag_out !== tg0 || ready_out !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL hold_stable: outputs changed or ready_out=1 while ready_in=0 (now valid=%b z=%0d ready_out=%b)",
               valid_out, z, ready_out);
    end
    t = t2; negate = 1'b1; mode = 1'b0; tag_in = 4'd11; valid_in = 1'b1; ready_in = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL handoff_ready: ready_out=%b, required 1", ready_out);
    end
    tick();
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || ready_out !== 1'b0) begin
      errors++;
      $display("FAIL handoff_accept: valid_out=%b ready_out=%b, required 0 0", valid_out, ready_out);
    end
    wait_result(lat, ok);
    $display("handoff: t=%0d -> z=%0d tag=%0d lat=%0d", t2, z, tag_out, lat);
    checks++;
    if (!ok || lat !== 36 || longint'(z) !== model_z(longint'(t2), 1'b1, 1'b0) || tag_out !== 4'd11) begin
      errors++;
      $display("FAIL handoff_result: ok=%b lat=%0d z=%0d tag=%0d, required lat=36 z=%0d tag=11",
               ok, lat, z, tag_out, model_z(longint'(t2), 1'b1, 1'b0));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic signed [31:0] bt[4];
    bit bn[4];
    longint rz[$];
    int rtag[$];
    int rcyc[$];
    int k;
    bit acc;
    for (int i = 0; i < 4; i++) begin
      bt[i] = 32'($urandom_range(0, 32'(TMAX)));
      bn[i] = 1'($urandom_range(0, 1));
    end
    ready_in = 1'b1;
    k = 0;
    t = bt[0]; negate = bn[0]; mode = 1'b0; tag_in = 4'd0; valid_in = 1'b1;
    #1;
    for (int i = 0; i < 300; i++) begin
      if (valid_out) begin
        rz.push_back(longint'(z));
        rtag.push_back(int'(tag_out));
        rcyc.push_back(cyc);
        $display("stream: result %0d z=%0d tag=%0d cycle=%0d", rz.size() - 1, z, tag_out, cyc);
      end
      if (rz.size() == 4) break;
      acc = valid_in && ready_out;
      tick();
      if (acc) begin
        k++;
        if (k < 4) begin
          t = bt[k]; negate = bn[k]; tag_in = 4'(k);
        end else begin
          valid_in = 1'b0;
        end
      end
    end
    valid_in = 1'b0;
    checks++;
    if (rz.size() != 4) begin
      errors++;
      $display("FAIL stream_count: %0d results, required 4", rz.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rtag[i] != i || rz[i] !== model_z(longint'(bt[i]), bn[i], 1'b0)) begin
          errors++;
          $display("FAIL stream_item%0d: z=%0d tag=%0d, required z=%0d tag=%0d",
                   i, rz[i], rtag[i], model_z(longint'(bt[i]), bn[i], 1'b0), i);
        end
        if (i > 0) begin
          checks++;
          if (rcyc[i] - rcyc[i-1] != 37) begin
            errors++;
            $display("FAIL stream_spacing%0d: %0d cycles, required 37", i, rcyc[i] - rcyc[i-1]);
          end
        end
      end
    end
    tick();
  endtask

  task automatic test_random();
    longint g;
    logic signed [31:0] tv;
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 9))
        0:       tv = -32'($urandom_range(1, 100000));
        1:       tv = 32'(TMAX) + 32'($urandom_range(1, 5000));
        default: tv = 32'($urandom_range(0, 32'(TMAX)));
      endcase
      run_item("random", tv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i), g);
    end
  endtask

  task automatic test_reset_mid_div();
    bit ok, stale;
    longint g;
    ready_in = 1'b1;
    send(32'sd200000, 1'b0, 1'b0, 4'd9, ok);
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_div: valid_out=%b ready_out=%b, required 0 1", valid_out, ready_out);
    end
    $display("reset mid-div: valid_out=%b ready_out=%b", valid_out, ready_out);
    tick(); tick();
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (valid_out !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL reset_stale: valid_out rose after reset with no item, required 0");
    end
    run_item("after_reset", 32'sd98304, 1'b1, 1'b1, 4'd12, g);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_two();
    test_clamp();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
